// File: rtl/aligned_ram_pkg.sv
// Shared constants, types and the alignment helper for the aligned scratch RAM.
package aligned_ram_pkg;

    localparam int RAM_DATA_W     = 32;
    localparam int RAM_ADDR_W     = 32;
    localparam int RAM_DEPTH_LOG2 = 8;
    localparam int WORD_BYTES     = 4;

    typedef logic [31:0] word_t;

    // A byte address is writable only when it falls on a 4-byte word boundary.
    function automatic logic is_aligned(input logic [RAM_ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/aligned_ram_if.sv
// Single-beat write bus between a write master and the aligned scratch RAM.
interface aligned_ram_if
    import aligned_ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);

    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              error;

    modport master (
        output wr_en,
        output addr,
        output wdata,
        input  error
    );

    modport slave (
        input  wr_en,
        input  addr,
        input  wdata,
        output error
    );

endinterface

// File: rtl/aligned_ram_store.sv
// Word array with synchronous write and a reset that clears every word.
module aligned_ram_store
    import aligned_ram_pkg::*;
#(
    parameter int DATA_W     = RAM_DATA_W,
    parameter int DEPTH_LOG2 = RAM_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]     wdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Reset wins over a concurrent write so a write during reset never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/aligned_ram.sv
// Write-only scratch RAM: aligned writes are stored, misaligned writes are
// dropped and reported on a registered error flag.
module aligned_ram
    import aligned_ram_pkg::*;
#(
    parameter int DATA_W     = RAM_DATA_W,
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int DEPTH_LOG2 = RAM_DEPTH_LOG2
) (
    input  logic         clk,
    input  logic         rst_n,
    aligned_ram_if.slave bus
);

    logic                  aligned_p0;
    logic                  we_p0;
    logic [DEPTH_LOG2-1:0] idx_p0;
    logic                  err_p1;
    logic                  unused_addr_hi;

    // Stage 0: decode the request on the bus.
    assign aligned_p0     = is_aligned(bus.addr);
    assign we_p0          = bus.wr_en & aligned_p0;
    assign idx_p0         = bus.addr[DEPTH_LOG2+1:2];
    // Upper address bits deliberately alias onto the array.
    assign unused_addr_hi = ^bus.addr[ADDR_W-1:DEPTH_LOG2+2];

    aligned_ram_store #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_store (
        .clk   (clk),
        .rst   (rst_n),
        .we    (we_p0),
        .idx   (idx_p0),
        .wdata (bus.wdata)
    );

    // Stage 1: status of the most recent write, held across idle cycles.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            err_p1 <= 1'b0;
        end else if (bus.wr_en) begin
            err_p1 <= ~aligned_p0;
        end
    end

    assign bus.error = err_p1;

endmodule

// File: tb/tb_aligned_ram.sv
// Scoreboard bench for aligned_ram: expected error flags are queued at drive
// time and retired one edge later; memory is compared against a shadow array.
module tb_aligned_ram;

    logic clk;
    logic rst_n;

    aligned_ram_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    aligned_ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] model [0:255];
    logic        exp_q [$];
    logic        last_err;
    int          n_vec;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, predict, retire after the rising edge.
    task automatic apply(input logic rst, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic e;
        @(negedge clk);
        rst_n     = rst;
        bus.wr_en = wr;
        bus.addr  = a;
        bus.wdata = d;
        if (rst) begin
            e = 1'b0;
            for (int i = 0; i < 256; i++) model[i] = '0;
        end else if (wr) begin
            e = (a[1:0] != 2'b00);
            if (!e) model[a[9:2]] = d;
        end else begin
            e = last_err;
        end
        last_err = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            chk("error", {31'd0, bus.error}, {31'd0, exp_q.pop_front()});
        end
    endtask

    task automatic chk_mem(input int i);
        chk($sformatf("mem[%0d]", i), dut.u_store.mem[i], model[i]);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        n_vec     = 0;
        n_err     = 0;
        last_err  = 1'b0;
        rst_n     = 1'b1;
        bus.wr_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;

        // Reset, then release and check the whole array is cleared.
        apply(1'b1, 1'b0, 32'h0, 32'h0);
        apply(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 256; i++) chk_mem(i);

        // Aligned write; error stays low through the following idle edge.
        apply(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        apply(1'b0, 1'b0, 32'h0, 32'h0);
        chk_mem(4);

        // Misaligned write is dropped and the flag holds while idle.
        apply(1'b0, 1'b1, 32'h0000_0013, 32'h1234_5678);
        apply(1'b0, 1'b0, 32'h0, 32'h0);
        apply(1'b0, 1'b0, 32'h0, 32'h0);
        chk_mem(4);

        // Every misaligned offset, then an aligned write clears the flag.
        for (int k = 1; k < 4; k++) begin
            apply(1'b0, 1'b1, 32'h0000_0020 + k, 32'hBAD0_0000 + k);
        end
        chk_mem(8);
        apply(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
        apply(1'b0, 1'b0, 32'h0, 32'h0);
        chk_mem(8);

        // Upper address bits alias onto the word index.
        apply(1'b0, 1'b1, 32'h0001_0008, 32'hA5A5_A5A5);
        chk_mem(2);

        // Put a flag up first so reset visibly clears it.
        apply(1'b0, 1'b1, 32'h0000_0005, 32'h0);
        apply(1'b1, 1'b1, 32'h0000_0001, 32'h1111_1111);
        apply(1'b1, 1'b1, 32'h0000_0004, 32'h2222_2222);
        apply(1'b0, 1'b0, 32'h0, 32'h0);
        chk_mem(1);
        chk_mem(4);
        chk_mem(8);

        // Random back-to-back writes.
        for (int n = 0; n < 10; n++) begin
            ra = $urandom;
            rd = $urandom;
            apply(1'b0, 1'b1, ra, rd);
            chk_mem(int'(ra[9:2]));
        end
        apply(1'b0, 1'b0, 32'h0, 32'h0);

        if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aligned_ram.md
Name: aligned_ram

Overview:
- Word-organised, write-only scratch RAM on a 32-bit byte-address bus.
- Accepts a write only when the byte address is 32-bit word aligned (addr[1:0] == 2'b00).
- Misaligned writes are dropped and flagged on a registered error output.
- Sits behind a simple single-beat write master; the error flag is sampled by the master or by status logic.

Parameters:
- DATA_W, 32, data word width in bits; fixed at 32, byte-lane alignment assumes 4-byte words.
- ADDR_W, 32, byte-address width.
- DEPTH_LOG2, 8, log2 of the number of words (default 256 words).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-high. Asserted when 1, despite the suffix; sampled on the rising edge of clk.
- wr_en  input  1  write request, one beat per cycle while high.
- addr  input  ADDR_W  byte address of the write.
- wdata  input  DATA_W  write data.
- error  output  1  registered misalignment flag for the most recent write request.

Behaviour:
- Reset (rst_n == 1 at a rising edge): error <= 0 and all memory words <= 0. Reset has priority over any write in the same cycle.
- Word index: idx = addr[DEPTH_LOG2+1:2]. Bits addr[ADDR_W-1:DEPTH_LOG2+2] are ignored, so upper addresses alias modulo DEPTH.
- Alignment: aligned = (addr[1:0] == 2'b00).
- Rising edge with wr_en == 1, reset low:
  - If aligned: mem[idx] <= wdata and error <= 0.
  - If misaligned: memory is unchanged and error <= 1.
- Rising edge with wr_en == 0, reset low: memory is unchanged and error holds its previous value.
  - error is "status of the last write" and stays valid until the next write or reset.
- Latency:
  - error reflects a request one edge after it is sampled. A request sampled at edge N gives error valid after edge N and stable through edge N+1 and beyond.
  - The write is committed at edge N.
- Back-to-back writes are allowed every cycle. error follows each request; there is no accumulation or sticky-OR.
- There is no read port. Contents are verified through the hierarchical array name mem[0:DEPTH-1].
- Reset asserted mid-stream: any concurrent write is discarded and error is cleared.
- X/Z on wr_en is outside the contract; no behaviour is required.

Decomposition:
- Package aligned_ram_pkg holds:
  - constants DATA_W, ADDR_W, DEPTH_LOG2 defaults;
  - localparam WORD_BYTES = 4;
  - typedef word_t (logic [31:0]);
  - a function is_aligned(addr) returning addr[1:0] == 0.
- One sub-module is natural: aligned_ram_store. It is a synchronous-write word array with reset clear and inputs we, idx, wdata.
- The top handles the alignment check, write gating and the error register.

Test Plan:
- Reset: hold rst_n = 1 for one edge, then release -> error == 0 and mem[0..255] == 0.
- Aligned write: wr_en = 1, addr = 32'h0000_0010, wdata = 32'hDEAD_BEEF for one edge, then wr_en = 0 -> error == 0 one edge later and still 0 after the following edge; mem[4] == 32'hDEAD_BEEF.
- Misaligned write: addr = 32'h0000_0013, wdata = 32'h1234_5678 -> error == 1 and held while wr_en == 0; mem[4] unchanged.
- Every misaligned offset: addr[1:0] = 1, 2, 3 each -> error == 1. A following aligned write to addr = 32'h0000_0020 -> error == 0 and mem[8] written.
- Aliasing: write 32'hA5A5_A5A5 to addr = 32'h0001_0008 -> mem[2] == 32'hA5A5_A5A5, error == 0.
- Reset vs write: rst_n = 1 and wr_en = 1 with addr = 32'h1, then addr = 32'h4 on the same edges -> error == 0 and mem[1] == 0. After release, 10 random addr/data writes -> error == (addr[1:0] != 0) after each.
